// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial N-bit adder sequencer time-sharing one full_adder cell
// Operands load in IDLE, one bit per enabled cycle in ADD, result held in DONE until taken.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fa_s, fa_cout;
    logic [N-1:0]  res_shift;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    generate
        if (N == 1) begin : g_n1
            assign res_shift = fa_s;
        end else begin : g_nx
            assign res_shift = {fa_s, res_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (ena) begin
                    res_d   = res_shift;
                    a_sh_d  = a_sh_q >> 1;
                    b_sh_d  = b_sh_q >> 1;
                    carry_d = fa_cout;
                    if (cnt_q == LAST) begin
                        // carry_q here is the carry into the MSB for this final step
                        sum_d   = res_shift;
                        cout_d  = fa_cout;
                        ovf_d   = carry_q ^ fa_cout;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at N=8, N=2 and N=1
module tb_serial_add_ctrl;
    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       of;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic       ena8, ena_drv, ena_rnd, rand_ena;
    logic       iv8, ir8, c8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;
    logic       iv2, ir2, c2, ov2, or2, co2, of2;
    logic [1:0] a2, b2, s2;
    logic       iv1, ir1, c1, ov1, or1, co1, of1;
    logic [0:0] a1, b1, s1;
    logic       one = 1'b1;
    logic       b2b = 1'b0;

    exp_t q8[$], q2[$], q1[$];
    int   acc_q[$], done_q[$];

    assign ena8 = rand_ena ? ena_rnd : ena_drv;

    serial_add_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(c8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .overflow(of8));
    serial_add_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .ena(one), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .cin(c2), .out_valid(ov2), .out_ready(or2),
        .sum(s2), .cout(co2), .overflow(of2));
    serial_add_ctrl #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .ena(one), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(c1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .overflow(of1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ena_rnd <= 1'($urandom_range(0, 1));

    // Reference: plain integer arithmetic, signed range test for overflow
    function automatic exp_t model(input int n, input int a, input int b, input int c);
        exp_t e;
        int full, lim, sa, sb, ss;
        lim  = 1 << (n - 1);
        full = a + b + c;
        sa   = (a >= lim) ? a - 2 * lim : a;
        sb   = (b >= lim) ? b - 2 * lim : b;
        ss   = sa + sb + c;
        e.s  = 8'(full % (1 << n));
        e.co = 1'((full >> n) & 1);
        e.of = (ss >= lim) || (ss < -lim);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && ov8 && or8) begin
            if (q8.size() == 0) fail_now("sb8_unexpected_result");
            else begin
                e = q8.pop_front();
                chk("sum8", s8, e.s);
                chk("cout8", co8, e.co);
                chk("ovf8", of8, e.of);
                chk("ready_in_done8", ir8, 0);
                if (b2b) done_q.push_back(cyc + 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && ov2 && or2) begin
            if (q2.size() == 0) fail_now("sb2_unexpected_result");
            else begin
                e = q2.pop_front();
                chk("sum2", s2, e.s);
                chk("cout2", co2, e.co);
                chk("ovf2", of2, e.of);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && ov1 && or1) begin
            if (q1.size() == 0) fail_now("sb1_unexpected_result");
            else begin
                e = q1.pop_front();
                chk("sum1", s1, e.s);
                chk("cout1", co1, e.co);
                chk("ovf1", of1, e.of);
            end
        end
    end

    task automatic put8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
        int t;
        a8 = a; b8 = b; c8 = c; iv8 = 1'b1; t = 0;
        @(negedge clk);
        while (!ir8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ir8) fail_now("put8_timeout");
        else begin
            @(posedge clk);
            q8.push_back(model(8, a, b, c));
            #1;
            acc_q.push_back(cyc);
        end
        if (!hold) iv8 = 1'b0;
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!ov8 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (!ov8) chk("busy_in_ready8", ir8, 0);
        end
    endtask

    task automatic drain8();
        int t;
        or8 = 1'b1; t = 0;
        while (q8.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (q8.size() != 0) fail_now("drain8_timeout");
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t;
        exp_t e;
        ena_drv = 1'b1; rand_ena = 1'b0;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; c8 = 0;
        iv2 = 0; or2 = 0; a2 = 0; b2 = 0; c2 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; c1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_sum", s8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ovf", of8, 0);
        rst = 1'b1;

        put8(8'h05, 8'h03, 1'b0, 0);
        wait_valid8(lat);
        chk("latency_basic", lat, 8);
        drain8();
        chk("ready_after_consume", ir8, 1);

        put8(8'hFF, 8'h01, 1'b0, 0); wait_valid8(lat); chk("latency_ff01", lat, 8); drain8();
        put8(8'h7F, 8'h01, 1'b0, 0); wait_valid8(lat); drain8();
        put8(8'h80, 8'h80, 1'b0, 0); wait_valid8(lat); drain8();

        // alternate ena from the edge after acceptance
        put8(8'h00, 8'h00, 1'b1, 0);
        lat = 0;
        while (!ov8 && lat < 64) begin
            ena_drv = ~ena_drv;
            @(posedge clk); #1;
            lat++;
        end
        ena_drv = 1'b1;
        chk("latency_stall", lat, 16);
        e = model(8, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a8 = 8'h11; b8 = 8'h00; c8 = 1'b0; iv8 = 1'b1;
            end
            @(posedge clk); #1;
            iv8 = 1'b0;
            chk("hold_sum", s8, e.s);
            chk("hold_cout", co8, e.co);
            chk("hold_ovf", of8, e.of);
            chk("hold_in_ready", ir8, 0);
            chk("hold_out_valid", ov8, 1);
        end
        drain8();
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_pulse_idle", ir8, 1);
        chk("ignored_pulse_no_result", ov8, 0);

        put8(8'hAA, 8'h55, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        void'(q8.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_in_ready", ir8, 1);
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_sum", s8, 0);
        chk("midrst_cout", co8, 0);
        chk("midrst_ovf", of8, 0);
        put8(8'h01, 8'h01, 1'b0, 0);
        drain8();

        rand_ena = 1'b1;
        or8 = 1'b1;
        for (int i = 0; i < 30; i++) put8(8'($urandom), 8'($urandom), 1'($urandom), 0);
        drain8();
        rand_ena = 1'b0;

        acc_q.delete();
        done_q.delete();
        b2b = 1'b1;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) put8(8'($urandom), 8'($urandom), 1'($urandom), 1);
        iv8 = 1'b0;
        drain8();
        b2b = 1'b0;
        chk("b2b_count", done_q.size(), 4);
        if (done_q.size() == 4 && acc_q.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b_spacing", done_q[i+1] - done_q[i], 10);
                chk("b2b_no_bypass", acc_q[i+1] - done_q[i], 1);
            end
        end

        iv2 = 1'b1; or2 = 1'b1;
        for (int v = 0; v < 32; v++) begin
            a2 = 2'(v >> 3); b2 = 2'(v >> 1); c2 = 1'(v);
            t = 0;
            @(negedge clk);
            while (!ir2 && t < 50) begin @(negedge clk); t++; end
            if (!ir2) fail_now("put2_timeout");
            else begin
                @(posedge clk);
                q2.push_back(model(2, int'(a2), int'(b2), int'(c2)));
                #1;
            end
        end
        iv2 = 1'b0;

        iv1 = 1'b1; or1 = 1'b1;
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); c1 = 1'(v);
            t = 0;
            @(negedge clk);
            while (!ir1 && t < 50) begin @(negedge clk); t++; end
            if (!ir1) fail_now("put1_timeout");
            else begin
                @(posedge clk);
                q1.push_back(model(1, int'(a1), int'(b1), int'(c1)));
                #1;
            end
        end
        iv1 = 1'b0;

        t = 0;
        while ((q2.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q2.size() != 0 || q1.size() != 0) fail_now("small_drain_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that time-shares one instance of the team's 1-bit `full_adder` cell (ports a, b, cin, s, cout) to add two N-bit operands bit-serially, LSB first.
- Accepts operands through a valid/ready input handshake.
- Steps the single adder for N enabled cycles, holding the ripple carry in a flop.
- Presents sum, carry-out and signed overflow through a valid/ready output handshake.
- It is the area-minimal arithmetic engine for the game-of-life neighbour-count path.

Parameters:
N, 8, operand/result width in bits; legal range N >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
ena  input  1  step enable; when low in ADD, all state holds.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  N  operand A.
b  input  N  operand B.
cin  input  1  carry-in to bit 0.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum  output  N  registered sum (a + b + cin) mod 2^N.
cout  output  1  carry out of bit N-1.
overflow  output  1  two's-complement overflow: carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
Reset
- rst low at a clock edge: state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; bit counter=0; carry flop=0.
- Reset mid-operation abandons the operation with no result produced.

State machine (IDLE, ADD, DONE)
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from the state register, not registered separately.

IDLE
- On in_valid & in_ready at an edge:
  - load a and b into shift registers;
  - carry <= cin; counter <= 0;
  - go to ADD.
- Otherwise hold. Input transfer does not depend on ena.

ADD
- Each edge with ena=1, the full_adder is driven with a_sh[0], b_sh[0] and carry. On that edge:
  - its s is shifted into the result register at the MSB (shift right);
  - a_sh and b_sh shift right;
  - carry <= cout; counter += 1.
- When the counter equals N-1, latch the carry-in of that step as cin_msb.
- Step with counter == N-1:
  - load sum <= completed result register;
  - cout <= adder cout;
  - overflow <= cin_msb XOR adder cout;
  - go to DONE.
- ena=0 stalls: no register changes.
- in_valid is ignored; in_ready=0.

DONE
- sum, cout and overflow are stable.
- On out_valid & out_ready go to IDLE; in_ready becomes 1 the following cycle.
- No same-cycle bypass: a new operand cannot be accepted on the same edge as the result is consumed.
- out_ready low holds DONE indefinitely.

Output registers and latency
- sum, cout and overflow change only on ADD->DONE or on reset. Between operations they retain the last result.
- Latency with ena held high: operands accepted at edge k, out_valid high after edge k+N. Each ena-low cycle in ADD adds one cycle.
- Minimum sustained throughput: one result per N+2 cycles.

Width and counter rules
- Counter width is max(1, $clog2(N)). It never exceeds N-1.
- N=1 case: a single ADD step transitions directly to DONE.

Simultaneous events
- rst low has priority over every handshake and over ena.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Test Plan:
1. N=8; a=8'h05, b=8'h03, cin=0 accepted at edge k, ena=1 -> out_valid first high after edge k+8; sum=8'h08, cout=0, overflow=0; in_ready=0 from edge k until the result is consumed.
2. Carry and overflow cases:
   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0.
   - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1.
   - a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, overflow=1.
3. Stall and backpressure:
   - a=8'h00, b=8'h00, cin=1 with ena toggling 1,0,1,0... from acceptance -> out_valid after 16 edges; sum=8'h01.
   - Then out_ready low 5 cycles -> sum/cout/overflow unchanged, in_ready=0, and an in_valid pulse with a=8'h11 is ignored.
4. Reset mid-add: a=8'hAA, b=8'h55 accepted; rst low for one edge after 3 ADD steps -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. A following a=8'h01, b=8'h01 -> sum=8'h02.
5. Back-to-back handshakes: in_valid and out_ready held high with 4 queued operand pairs -> results in order, each exactly N+2 cycles apart. Verify no operand is accepted on the same edge as the result is consumed.
6. N=2 exhaustive: all 32 (a, b, cin) combinations -> {cout, sum} == a+b+cin, and overflow matches the signed 2-bit reference for every case. Repeat the sweep with N=1.
